// File: rtl/sargantana_icache_fill_ctrl.sv
// Instruction-cache array sequencer: grants fetch lookups, writes refill lines
// into a chosen victim way, and clears every valid bit on a flush.
module sargantana_icache_fill_ctrl #(
  parameter int ICACHE_N_WAY = 4,
  parameter int SET_WIDHT    = 256,
  parameter int TAG_WIDHT    = 20,
  parameter int ADDR_WIDHT   = 6
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    lookup_req_i,
  input  logic [ADDR_WIDHT-1:0]   lookup_idx_i,
  output logic                    lookup_gnt_o,
  input  logic                    refill_valid_i,
  output logic                    refill_ready_o,
  input  logic [ADDR_WIDHT-1:0]   refill_idx_i,
  input  logic [TAG_WIDHT-1:0]    refill_tag_i,
  input  logic [SET_WIDHT-1:0]    refill_data_i,
  input  logic                    flush_i,
  output logic                    busy_o,
  output logic                    flush_done_o,
  output logic [ICACHE_N_WAY-1:0] tag_req_o,
  output logic [ICACHE_N_WAY-1:0] data_req_o,
  output logic                    tag_we_o,
  output logic                    data_we_o,
  output logic                    flush_en_o,
  output logic                    valid_bit_o,
  output logic [TAG_WIDHT-1:0]    tag_o,
  output logic [SET_WIDHT-1:0]    cline_o,
  output logic [ADDR_WIDHT-1:0]   addr_o,
  input  logic [ICACHE_N_WAY-1:0] vbit_i
);

  localparam int WAY_W = (ICACHE_N_WAY > 1) ? $clog2(ICACHE_N_WAY) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VREAD  = 2'd1,
    VWRITE = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [WAY_W-1:0]      rr_q, rr_d;
  logic [WAY_W-1:0]      victim_q, victim_d;
  logic [WAY_W-1:0]      free_way_s;
  logic                  free_found_s;
  logic [ADDR_WIDHT-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDHT-1:0] idx_q, idx_d;
  logic [TAG_WIDHT-1:0]  tag_q, tag_d;
  logic [SET_WIDHT-1:0]  data_q, data_d;
  logic                  flush_pend_q, flush_pend_d;

  // Lowest-index way whose valid bit is clear.
  always_comb begin
    free_found_s = ~(&vbit_i);
    free_way_s   = {WAY_W{1'b0}};
    for (int i = ICACHE_N_WAY - 1; i >= 0; i--) begin
      free_way_s = (!vbit_i[i]) ? WAY_W'(i) : free_way_s;
    end
  end

  // Next-state and array-side outputs; all outputs forced low while in reset.
  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    victim_d       = victim_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    tag_d          = tag_q;
    data_d         = data_q;
    flush_pend_d   = flush_pend_q;
    lookup_gnt_o   = 1'b0;
    refill_ready_o = 1'b0;
    busy_o         = 1'b0;
    flush_done_o   = 1'b0;
    tag_req_o      = {ICACHE_N_WAY{1'b0}};
    data_req_o     = {ICACHE_N_WAY{1'b0}};
    tag_we_o       = 1'b0;
    data_we_o      = 1'b0;
    flush_en_o     = 1'b0;
    valid_bit_o    = 1'b0;
    tag_o          = {TAG_WIDHT{1'b0}};
    cline_o        = {SET_WIDHT{1'b0}};
    addr_o         = {ADDR_WIDHT{1'b0}};

    if (!rstn_i) begin
      state_d = IDLE;
    end else begin
      busy_o = (state_q != IDLE) || flush_pend_q;
      case (state_q)
        IDLE: begin
          if (flush_i || flush_pend_q) begin
            state_d      = FLUSH;
            cnt_d        = {ADDR_WIDHT{1'b0}};
            flush_pend_d = 1'b0;
          end else if (refill_valid_i) begin
            refill_ready_o = 1'b1;
            idx_d          = refill_idx_i;
            tag_d          = refill_tag_i;
            data_d         = refill_data_i;
            tag_req_o      = {ICACHE_N_WAY{1'b1}};
            addr_o         = refill_idx_i;
            state_d        = VREAD;
          end else if (lookup_req_i) begin
            lookup_gnt_o = 1'b1;
            tag_req_o    = {ICACHE_N_WAY{1'b1}};
            data_req_o   = {ICACHE_N_WAY{1'b1}};
            addr_o       = lookup_idx_i;
          end else begin
            state_d = IDLE;
          end
        end
        VREAD: begin
          // The round-robin pointer only advances when it actually picks the victim.
          if (free_found_s) begin
            victim_d = free_way_s;
          end else begin
            victim_d = rr_q;
            rr_d     = (rr_q == WAY_W'(ICACHE_N_WAY - 1)) ? {WAY_W{1'b0}} : rr_q + WAY_W'(1);
          end
          flush_pend_d = flush_pend_q | flush_i;
          state_d      = VWRITE;
        end
        VWRITE: begin
          tag_req_o    = ICACHE_N_WAY'(1) << victim_q;
          data_req_o   = ICACHE_N_WAY'(1) << victim_q;
          tag_we_o     = 1'b1;
          data_we_o    = 1'b1;
          valid_bit_o  = 1'b1;
          tag_o        = tag_q;
          cline_o      = data_q;
          addr_o       = idx_q;
          flush_pend_d = flush_pend_q | flush_i;
          state_d      = IDLE;
        end
        FLUSH: begin
          tag_req_o  = {ICACHE_N_WAY{1'b1}};
          tag_we_o   = 1'b1;
          flush_en_o = 1'b1;
          addr_o     = cnt_q;
          if (cnt_q == {ADDR_WIDHT{1'b1}}) begin
            flush_done_o = 1'b1;
            state_d      = IDLE;
          end else begin
            cnt_d = cnt_q + ADDR_WIDHT'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and capture registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      rr_q         <= {WAY_W{1'b0}};
      victim_q     <= {WAY_W{1'b0}};
      cnt_q        <= {ADDR_WIDHT{1'b0}};
      idx_q        <= {ADDR_WIDHT{1'b0}};
      tag_q        <= {TAG_WIDHT{1'b0}};
      data_q       <= {SET_WIDHT{1'b0}};
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      victim_q     <= victim_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      flush_pend_q <= flush_pend_d;
    end
  end

endmodule

// File: tb/tb_sargantana_icache_fill_ctrl.sv
// Scoreboard bench: transaction tasks queue the expected array-side picture per
// cycle; a monitor compares it against the DUT on the falling edge.
module tb_sargantana_icache_fill_ctrl;
  localparam int N  = 4;
  localparam int SW = 256;
  localparam int TW = 20;
  localparam int AW = 6;
  localparam int NSETS = 1 << AW;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          lookup_req_i;
  logic [AW-1:0] lookup_idx_i;
  logic          lookup_gnt_o;
  logic          refill_valid_i;
  logic          refill_ready_o;
  logic [AW-1:0] refill_idx_i;
  logic [TW-1:0] refill_tag_i;
  logic [SW-1:0] refill_data_i;
  logic          flush_i;
  logic          busy_o;
  logic          flush_done_o;
  logic [N-1:0]  tag_req_o;
  logic [N-1:0]  data_req_o;
  logic          tag_we_o;
  logic          data_we_o;
  logic          flush_en_o;
  logic          valid_bit_o;
  logic [TW-1:0] tag_o;
  logic [SW-1:0] cline_o;
  logic [AW-1:0] addr_o;
  logic [N-1:0]  vbit_i;

  sargantana_icache_fill_ctrl #(
    .ICACHE_N_WAY(N), .SET_WIDHT(SW), .TAG_WIDHT(TW), .ADDR_WIDHT(AW)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .lookup_req_i(lookup_req_i), .lookup_idx_i(lookup_idx_i), .lookup_gnt_o(lookup_gnt_o),
    .refill_valid_i(refill_valid_i), .refill_ready_o(refill_ready_o),
    .refill_idx_i(refill_idx_i), .refill_tag_i(refill_tag_i), .refill_data_i(refill_data_i),
    .flush_i(flush_i), .busy_o(busy_o), .flush_done_o(flush_done_o),
    .tag_req_o(tag_req_o), .data_req_o(data_req_o),
    .tag_we_o(tag_we_o), .data_we_o(data_we_o), .flush_en_o(flush_en_o),
    .valid_bit_o(valid_bit_o), .tag_o(tag_o), .cline_o(cline_o), .addr_o(addr_o),
    .vbit_i(vbit_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc_cnt = 0;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  typedef struct packed {
    logic          gnt, rdy, busy, twe, dwe, fen, done, vb;
    logic [N-1:0]  treq, dreq;
    logic [AW-1:0] addr;
    logic [TW-1:0] tag;
    logic [SW-1:0] cline;
  } outs_t;

  typedef struct {
    int    cyc;
    outs_t o;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rr_m     = 0;

  function automatic outs_t z();
    outs_t o;
    o = '0;
    return o;
  endfunction

  function automatic void push(outs_t o);
    exp_t e;
    e.cyc = cyc_cnt;
    e.o   = o;
    sb_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic noise();
    lookup_idx_i  = AW'($urandom);
    refill_idx_i  = AW'($urandom);
    refill_tag_i  = TW'($urandom);
    refill_data_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    vbit_i        = N'($urandom);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Monitor: compare the queued expectation for this cycle, or flag unexpected activity.
  initial begin
    outs_t a;
    exp_t  e;
    forever begin
      @(negedge clk_i);
      a = '{gnt: lookup_gnt_o, rdy: refill_ready_o, busy: busy_o, twe: tag_we_o, dwe: data_we_o,
            fen: flush_en_o, done: flush_done_o, vb: valid_bit_o, treq: tag_req_o, dreq: data_req_o,
            addr: addr_o, tag: tag_o, cline: cline_o};
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc_cnt) begin
        e = sb_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missed_cycle expected at cyc=%0d now cyc=%0d", e.cyc, cyc_cnt);
      end
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc_cnt) begin
        e = sb_q.pop_front();
        n_checks++;
        if (a !== e.o) begin
          n_fail++;
          $display("FAIL outputs cyc=%0d got gnt=%b rdy=%b busy=%b twe=%b dwe=%b fen=%b done=%b vb=%b treq=%h dreq=%h addr=%0d tag=%h cline=%h",
                   cyc_cnt, a.gnt, a.rdy, a.busy, a.twe, a.dwe, a.fen, a.done, a.vb, a.treq, a.dreq, a.addr, a.tag, a.cline);
          $display("  required gnt=%b rdy=%b busy=%b twe=%b dwe=%b fen=%b done=%b vb=%b treq=%h dreq=%h addr=%0d tag=%h cline=%h",
                   e.o.gnt, e.o.rdy, e.o.busy, e.o.twe, e.o.dwe, e.o.fen, e.o.done, e.o.vb, e.o.treq, e.o.dreq, e.o.addr, e.o.tag, e.o.cline);
        end
      end else if (a !== '0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output cyc=%0d got treq=%h addr=%0d gnt=%b rdy=%b busy=%b required all zero",
                 cyc_cnt, a.treq, a.addr, a.gnt, a.rdy, a.busy);
      end
    end
  end

  task automatic idle_cyc(bit lk, int idx);
    outs_t o;
    tick();
    noise();
    flush_i = 1'b0;
    refill_valid_i = 1'b0;
    lookup_req_i = lk;
    if (idx >= 0) lookup_idx_i = AW'(idx);
    o = z();
    if (lk) begin
      o.gnt = 1'b1; o.treq = '1; o.dreq = '1; o.addr = lookup_idx_i;
    end
    push(o);
  endtask

  task automatic do_flush(bit pend, bit hold_refill, int abort_at);
    outs_t o;
    tick();
    noise();
    refill_valid_i = hold_refill;
    lookup_req_i = rbit();
    o = z();
    if (pend) begin
      flush_i = rbit();
      o.busy = 1'b1;
    end else begin
      flush_i = 1'b1;
    end
    push(o);
    for (int k = 0; k < NSETS; k++) begin
      tick();
      noise();
      flush_i = rbit();
      refill_valid_i = hold_refill;
      lookup_req_i = rbit();
      if (k == abort_at) begin
        // Mid-flush reset: outputs silent, then lookups granted right after release.
        rstn_i = 1'b0; lookup_req_i = 1'b1; refill_valid_i = 1'b1; flush_i = 1'b1;
        push(z());
        tick();
        noise();
        push(z());
        tick();
        noise();
        rstn_i = 1'b1; lookup_req_i = 1'b1; refill_valid_i = 1'b0; flush_i = 1'b0;
        o = z();
        o.gnt = 1'b1; o.treq = '1; o.dreq = '1; o.addr = lookup_idx_i;
        push(o);
        rr_m = 0;
        return;
      end
      o = z();
      o.busy = 1'b1; o.treq = '1; o.twe = 1'b1; o.fen = 1'b1;
      o.addr = AW'(k); o.done = (k == NSETS - 1);
      push(o);
    end
  endtask

  task automatic do_refill(logic [AW-1:0] idx, logic [TW-1:0] tag, logic [SW-1:0] data,
                           logic [N-1:0] vb, bit fl);
    outs_t o;
    int    v;
    tick();
    noise();
    flush_i = 1'b0; refill_valid_i = 1'b1; lookup_req_i = rbit();
    refill_idx_i = idx; refill_tag_i = tag; refill_data_i = data;
    o = z();
    o.rdy = 1'b1; o.treq = '1; o.addr = idx;
    push(o);
    tick();
    noise();
    refill_valid_i = rbit(); lookup_req_i = rbit(); vbit_i = vb; flush_i = fl;
    o = z();
    o.busy = 1'b1;
    push(o);
    v = -1;
    for (int i = 0; i < N; i++) if (!vb[i] && v < 0) v = i;
    if (v < 0) begin
      v = rr_m;
      rr_m = (rr_m + 1) % N;
    end
    tick();
    noise();
    refill_valid_i = rbit(); lookup_req_i = rbit(); flush_i = fl ? rbit() : 1'b0;
    o = z();
    o.busy = 1'b1; o.twe = 1'b1; o.dwe = 1'b1; o.vb = 1'b1;
    o.treq = N'(1 << v); o.dreq = N'(1 << v);
    o.addr = idx; o.tag = tag; o.cline = data;
    push(o);
    if (fl) do_flush(1'b1, 1'b0, -1);
  endtask

  function automatic logic [SW-1:0] rdata();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int r;
    rstn_i = 1'b0; lookup_req_i = 1'b1; refill_valid_i = 1'b1; flush_i = 1'b1;
    lookup_idx_i = '0; refill_idx_i = '0; refill_tag_i = '0; refill_data_i = '0; vbit_i = '0;
    repeat (3) begin
      tick();
      push(z());
    end
    tick();
    rstn_i = 1'b1; lookup_req_i = 1'b0; refill_valid_i = 1'b0; flush_i = 1'b0;
    push(z());

    idle_cyc(1'b1, 5);
    idle_cyc(1'b0, -1);
    do_refill(AW'(9), TW'(20'hABCDE), rdata(), 4'b1011, 1'b0);
    repeat (5) do_refill(AW'($urandom), TW'($urandom), rdata(), 4'b1111, 1'b0);
    do_flush(1'b0, 1'b0, -1);
    do_flush(1'b0, 1'b1, -1);
    do_refill(AW'($urandom), TW'($urandom), rdata(), N'($urandom), 1'b0);
    do_refill(AW'($urandom), TW'($urandom), rdata(), 4'b1111, 1'b1);
    idle_cyc(1'b1, -1);
    do_flush(1'b0, 1'b0, 20);
    do_refill(AW'($urandom), TW'($urandom), rdata(), 4'b1111, 1'b0);

    for (int t = 0; t < 60; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        idle_cyc(rbit(), -1);
      end else if (r < 8) begin
        do_refill(AW'($urandom), TW'($urandom), rdata(),
                  ($urandom_range(0, 2) == 0) ? 4'b1111 : N'($urandom), 1'b0);
      end else if (r == 8) begin
        do_flush(1'b0, rbit(), -1);
      end else begin
        do_refill(AW'($urandom), TW'($urandom), rdata(), N'($urandom), 1'b1);
      end
    end
    repeat (3) idle_cyc(1'b0, -1);
    tick();
    lookup_req_i = 1'b0; refill_valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
